// File: rtl/ff_addsub_serial.sv
// Limb-serial modular adder/subtractor over GF(P).
// Two limb chains run in lock-step: r = a +/- b, and its correction
// d = r -/+ P. SELECT picks whichever one is the reduced result.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request strobe, accepted in IDLE or DONE
//   op_i            0: (a+b) mod P, 1: (a-b) mod P
//   a_i, b_i        operands (expected < P)
//   out             result, held until the next SELECT
//   done            one-cycle result-valid pulse
//   busy            high during COMPUTE and SELECT
module ff_addsub_serial #(
    parameter int unsigned WIDTH = 255,
    parameter int unsigned LIMB  = 64,
    parameter logic [WIDTH-1:0] P = {{(WIDTH-5){1'b1}}, 5'b01101}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             busy
);

    localparam int unsigned NLIMB = (WIDTH + LIMB - 1) / LIMB;
    localparam int unsigned W2    = NLIMB * LIMB;
    localparam int unsigned LW    = LIMB + 1;
    localparam int unsigned CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [W2-1:0] P_PAD = W2'(P);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        SELECT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            done_n;
    logic            busy_n;
    logic            load;
    logic            step;

    logic [W2-1:0]   a_sh;
    logic [W2-1:0]   b_sh;
    logic [W2-1:0]   p_sh;
    logic [W2-1:0]   r_q;
    logic [W2-1:0]   d_q;
    logic            c1;
    logic            c2;
    logic            op_q;
    logic [CW-1:0]   k;

    logic [LW-1:0]   sum1;
    logic [LW-1:0]   sum2;
    logic [LIMB-1:0] r_l;
    logic [LIMB-1:0] d_l;
    logic            last;
    logic            use_d;

    // Limb arithmetic: operands are shifted down so limb k is always at bit 0.
    always_comb begin
        sum1 = op_q ? ({1'b0, a_sh[LIMB-1:0]} - {1'b0, b_sh[LIMB-1:0]} - LW'(c1))
                    : ({1'b0, a_sh[LIMB-1:0]} + {1'b0, b_sh[LIMB-1:0]} + LW'(c1));
        r_l  = sum1[LIMB-1:0];
        sum2 = op_q ? ({1'b0, r_l} + {1'b0, p_sh[LIMB-1:0]} + LW'(c2))
                    : ({1'b0, r_l} - {1'b0, p_sh[LIMB-1:0]} - LW'(c2));
        d_l  = sum2[LIMB-1:0];
        last = (k == CW'(NLIMB - 1));
        // Add: a carry out of r (only possible when W2 == WIDTH) also means a+b >= P.
        use_d = op_q ? c1 : (c1 | ~c2);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and registered-output next values.
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        busy_n  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    busy_n  = 1'b1;
                    state_n = COMPUTE;
                end else begin
                    state_n = IDLE;
                end
            end
            COMPUTE: begin
                step   = 1'b1;
                busy_n = 1'b1;
                if (last) begin
                    state_n = SELECT;
                end
            end
            SELECT: begin
                done_n  = 1'b1;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand capture, limb shifting, result selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            p_sh <= '0;
            r_q  <= '0;
            d_q  <= '0;
            c1   <= 1'b0;
            c2   <= 1'b0;
            op_q <= 1'b0;
            k    <= '0;
            out  <= '0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= done_n;
            busy <= busy_n;
            if (load) begin
                a_sh <= W2'(a_i);
                b_sh <= W2'(b_i);
                p_sh <= P_PAD;
                op_q <= op_i;
                c1   <= 1'b0;
                c2   <= 1'b0;
                k    <= '0;
            end
            if (step) begin
                a_sh <= a_sh >> LIMB;
                b_sh <= b_sh >> LIMB;
                p_sh <= p_sh >> LIMB;
                // New limb enters at the top; after NLIMB steps limb 0 sits at bit 0.
                r_q  <= (r_q >> LIMB) | (W2'(r_l) << (W2 - LIMB));
                d_q  <= (d_q >> LIMB) | (W2'(d_l) << (W2 - LIMB));
                c1   <= sum1[LIMB];
                c2   <= sum2[LIMB];
                k    <= k + CW'(1);
            end
            if (state == SELECT) begin
                out <= use_d ? d_q[WIDTH-1:0] : r_q[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ff_addsub_serial.sv
// Bench for ff_addsub_serial: four instances (LIMB = 64, 32, 1, 255), each
// with its own driver and a scoreboard monitor checked against (a +/- b) mod P.
module tb_ff_addsub_serial;

    localparam int unsigned WIDTH     = 255;
    localparam int unsigned SW        = WIDTH + 2;
    localparam int unsigned NCFG      = 4;
    localparam int unsigned NDIR      = 13;
    localparam int unsigned CYC_LIMIT = 90000;
    localparam logic [255:0] P_WIDE   = (256'd1 << 255) - 256'd19;
    localparam logic [WIDTH-1:0] PM   = P_WIDE[WIDTH-1:0];

    typedef struct {
        logic [WIDTH-1:0] val;
        int unsigned      t;
    } exp_t;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [WIDTH-1:0] dir_a [NDIR];
    logic [WIDTH-1:0] dir_b [NDIR];
    bit               dir_op[NDIR];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned limb_of(input int unsigned g);
        case (g)
            0:       return 64;
            1:       return 32;
            2:       return 1;
            default: return 255;
        endcase
    endfunction

    // Reference: plain modular arithmetic on wide integers.
    function automatic logic [WIDTH-1:0] model(input bit o, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        logic [SW-1:0] s;
        if (!o) begin
            s = SW'(x) + SW'(y);
            if (s >= SW'(PM)) s = s - SW'(PM);
        end else if (x >= y) begin
            s = SW'(x) - SW'(y);
        end else begin
            s = SW'(x) + SW'(PM) - SW'(y);
        end
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] dec(input string s);
        logic [SW-1:0] v = '0;
        for (int i = 0; i < s.len(); i++) v = v * SW'(10) + SW'(int'(s[i]) - 48);
        return v[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] rand_fe();
        logic [255:0] v;
        do begin
            for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        end while (v[WIDTH-1:0] >= PM);
        return v[WIDTH-1:0];
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    initial begin
        dir_op[0]  = 1'b0; dir_a[0]  = 255'd5;            dir_b[0]  = 255'd7;
        dir_op[1]  = 1'b0; dir_a[1]  = PM - 255'd1;       dir_b[1]  = 255'd1;
        dir_op[2]  = 1'b0; dir_a[2]  = PM - 255'd1;       dir_b[2]  = PM - 255'd1;
        dir_op[3]  = 1'b0; dir_a[3]  = 255'd1 << 254;     dir_b[3]  = 255'd1 << 254;
        dir_op[4]  = 1'b1; dir_a[4]  = 255'd3;            dir_b[4]  = 255'd5;
        dir_op[5]  = 1'b1; dir_a[5]  = 255'h1234;         dir_b[5]  = 255'h1234;
        dir_op[6]  = 1'b1; dir_a[6]  = PM - 255'd1;       dir_b[6]  = 255'd0;
        dir_a[7] = dec("44927731495623270119727621215091840270797887326986279676957494683529379806913");
        dir_b[7] = dec("45965849458578823337785628114947185621072782472466027602082789798859530730301");
        dir_op[7]  = 1'b0;
        dir_op[8]  = 1'b1; dir_a[8]  = dir_a[7];          dir_b[8]  = dir_b[7];
        dir_op[9]  = 1'b0; dir_a[9]  = PM - 255'd5;       dir_b[9]  = 255'd5;
        dir_op[10] = 1'b1; dir_a[10] = 255'd0;            dir_b[10] = PM - 255'd1;
        dir_op[11] = 1'b0; dir_a[11] = 255'd0;            dir_b[11] = 255'd0;
        dir_op[12] = 1'b1; dir_a[12] = dir_b[7];          dir_b[12] = dir_a[7];
    end

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int unsigned L     = limb_of(g);
        localparam int unsigned NL    = (WIDTH + L - 1) / L;
        localparam int unsigned NRAND = (L == 1) ? 30 : 1000;

        logic             rst;
        logic             start;
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] out;
        logic             done;
        logic             busy;
        exp_t             q[$];
        bit               fin = 1'b0;
        logic [WIDTH-1:0] hold = '0;
        int unsigned      run = 0;

        ff_addsub_serial #(.WIDTH(WIDTH), .LIMB(L)) dut (
            .clk  (clk),
            .rst  (rst),
            .start(start),
            .op_i (op),
            .a_i  (a),
            .b_i  (b),
            .out  (out),
            .done (done),
            .busy (busy)
        );

        // Monitor: pops an expectation on every done, checks result, latency,
        // busy length and that out holds between results.
        initial begin
            exp_t e;
            forever begin
                @(posedge clk);
                #1;
                if (rst) begin
                    hold = '0;
                    run  = 0;
                end
                if (busy) begin
                    run++;
                end else if (run != 0) begin
                    check($sformatf("L%0d busy_cycles", L), WIDTH'(run), WIDTH'(NL + 1));
                    run = 0;
                end
                if (done) begin
                    if (q.size() == 0) begin
                        check($sformatf("L%0d unexpected_done", L), WIDTH'(done), '0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("L%0d result", L), out, e.val);
                        check($sformatf("L%0d latency", L), WIDTH'(cyc - e.t), WIDTH'(NL + 1));
                        hold = e.val;
                    end
                end else begin
                    check($sformatf("L%0d out_hold", L), out, hold);
                end
            end
        end

        task automatic wait_idle();
            int unsigned n = 0;
            while (busy && n < NL + 8) begin
                @(negedge clk);
                n++;
            end
            if (busy) check($sformatf("L%0d idle_timeout", L), WIDTH'(busy), '0);
        endtask

        task automatic issue(input bit o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                             input int unsigned gap, input bit keep);
            exp_t e;
            wait_idle();
            repeat (gap) @(negedge clk);
            start = 1'b1;
            op    = o;
            a     = x;
            b     = y;
            @(posedge clk);
            #1;
            if (keep) begin
                e.val = model(o, x, y);
                e.t   = cyc;
                q.push_back(e);
            end
            @(negedge clk);
            start = 1'b0;
            op    = 1'($urandom);
            a     = rand_fe();
            b     = rand_fe();
            check($sformatf("L%0d busy_after_start", L), WIDTH'(busy), WIDTH'(1));
        endtask

        initial begin
            logic [WIDTH-1:0] x;
            logic [WIDTH-1:0] y;
            rst   = 1'b1;
            start = 1'b0;
            op    = 1'b0;
            a     = '0;
            b     = '0;
            @(negedge clk);
            @(negedge clk);
            check($sformatf("L%0d reset_out", L), out, '0);
            check($sformatf("L%0d reset_done", L), WIDTH'(done), '0);
            check($sformatf("L%0d reset_busy", L), WIDTH'(busy), '0);
            rst = 1'b0;

            for (int i = 0; i < NDIR; i++) issue(dir_op[i], dir_a[i], dir_b[i], i % 2, 1'b1);

            // start pulsed mid-COMPUTE with other operands must be ignored
            issue(1'b0, dir_a[7], dir_b[7], 1, 1'b1);
            start = 1'b1;
            op    = 1'b1;
            a     = rand_fe();
            b     = rand_fe();
            @(negedge clk);
            start = 1'b0;

            // reset mid-COMPUTE discards the operation
            issue(1'b1, dir_a[8], dir_b[8], 0, 1'b0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check($sformatf("L%0d midreset_out", L), out, '0);
            check($sformatf("L%0d midreset_busy", L), WIDTH'(busy), '0);
            repeat (NL + 4) @(negedge clk);
            issue(1'b1, 255'd3, 255'd5, 0, 1'b1);

            for (int i = 0; i < NRAND; i++) begin
                x = ($urandom_range(0, 15) == 0) ? PM - 255'd1 : rand_fe();
                y = ($urandom_range(0, 15) == 0) ? PM - 255'd1 : rand_fe();
                issue(1'($urandom), x, y,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 1'b1);
            end

            wait_idle();
            repeat (3) @(negedge clk);
            check($sformatf("L%0d pending", L), WIDTH'(q.size()), '0);
            fin = 1'b1;
        end
    end

    initial begin
        while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin) && cyc < CYC_LIMIT)
            @(posedge clk);
        if (cyc >= CYC_LIMIT) begin
            checks++;
            failures++;
            $display("FAIL global_timeout: cycle %0d reached, required all runs finished", cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ff_addsub_serial.md
Name: ff_addsub_serial

Overview:
- Parametrised, limb-serial modular adder/subtractor over GF(P). Default field is P = 2^255-19.
- Sits next to the existing field-arithmetic units in the ECC scalar-multiplication datapath and uses the same start/done operand interface.
- Successor to the fixed single-function 255-bit field units. It adds:
  - runtime add/sub mode select;
  - configurable limb width, trading latency against carry-chain length;
  - a busy flag.

Parameters:
- WIDTH, 255, operand and result width in bits.
- LIMB, 64, bits processed per COMPUTE cycle. Must satisfy 1 <= LIMB <= WIDTH.
- P, 2^255-19, field modulus. Requires 2^(WIDTH-1) < P < 2^WIDTH.
- Derived, not a port: NLIMB = ceil(WIDTH/LIMB). Internal width W2 = NLIMB*LIMB; operands are zero-padded to W2.

Ports:
- clk    in   1      clock; all logic on the rising edge.
- rst    in   1      synchronous, active-high reset.
- start  in   1      request strobe; sampled only when the block is not busy.
- op_i   in   1      0 = out = (a+b) mod P; 1 = out = (a-b) mod P. Captured with start.
- a_i    in   WIDTH  operand a; precondition a < P. Captured with start.
- b_i    in   WIDTH  operand b; precondition b < P. Captured with start.
- out    out  WIDTH  result; valid from the done cycle and held until the next accepted start or rst.
- done   out  1      one-cycle pulse: result valid.
- busy   out  1      high in COMPUTE and SELECT.

Behaviour:
- Reset (rst=1 at a clock edge), from any state including mid-operation:
  - state <= IDLE; out, done, busy, limb counter, carry/borrow flags and operand registers <= 0.
  - An in-flight operation is discarded; no done is produced for it.
- States: IDLE, COMPUTE, SELECT, DONE.
- IDLE:
  - start=1 latches a_i, b_i, op_i, clears both carry flags, sets limb counter k=0, and goes to COMPUTE.
  - done=0, busy=0.
- COMPUTE, NLIMB cycles. Cycle k handles bits [k*LIMB +: LIMB] of the padded operands with two parallel limb chains:
  - Primary chain r = a + b (op=0) or a - b (op=1), with carry/borrow c1 propagated between limbs.
  - Correction chain d = r - P (op=0) or r + P (op=1). It uses limb k of r from the same cycle and its own flag c2.
  - r and d limbs are shifted into W2-bit registers.
  - The cycle with k = NLIMB-1 goes to SELECT.
- SELECT, 1 cycle:
  - op=0: out <= d[WIDTH-1:0] if the full-width (a+b)-P did not borrow, i.e. a+b >= P; else out <= r[WIDTH-1:0].
  - op=1: out <= d[WIDTH-1:0] if a-b borrowed, i.e. a < b; else out <= r[WIDTH-1:0].
  - Then go to DONE.
- DONE, 1 cycle:
  - done=1, busy=0.
  - start=1 in this cycle is accepted exactly as in IDLE, going directly to COMPUTE. Otherwise go to IDLE.
- Latency: start accepted at edge T gives done=1 during the cycle after edge T+NLIMB+1. Defaults: 5 cycles; LIMB=32: 9 cycles; LIMB=255: 2 cycles.
- Throughput: one operation per NLIMB+2 cycles.
- start in COMPUTE or SELECT is ignored. Changes to a_i/b_i/op_i while busy have no effect.
- out is unchanged from the DONE cycle until SELECT of the next operation.
- Width rules:
  - Result is always < P for in-range inputs.
  - Out-of-range inputs (>= P) give an unspecified but deterministic result, and the protocol still completes normally.
  - Padding bits above WIDTH must be zero in r/d selection. Only [WIDTH-1:0] is output.
- Tie case: a+b == P gives out = 0 (the correction chain wins on no-borrow).

Test Plan:
- Small add, default params: op=0, a=5, b=7 -> out=12; done pulses exactly 5 cycles after the start edge; busy high for 4+1 cycles.
- Wrap add: a=P-1, b=1 -> out=0. a=P-1, b=P-1 -> out=P-2. a=2^254, b=2^254 -> out=19.
- Subtract: a=3, b=5 -> out=P-2. a=b=0x1234 -> out=0. a=P-1, b=0 -> out=P-1.
- Large random: a=44927731495623270119727621215091840270797887326986279676957494683529379806913, b=45965849458578823337785628114947185621072782472466027602082789798859530730301.
  - Both ops -> match bench (a±b) mod P. Repeat 1000 random in-range vectors.
- Control: start re-asserted during COMPUTE is ignored (single done). start held high in the DONE cycle -> next operation runs back-to-back with no idle cycle.
  - rst asserted mid-COMPUTE -> out=0, done never pulses, next start works normally.
- Parameter sweep with LIMB=32, LIMB=1 and LIMB=255, same vectors.
  - Results identical; done latency NLIMB+1 (9, 256, 2 cycles respectively).
